// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command becomes one single-beat bus cycle,
// bounded by a timeout and answered on a valid/ready response channel.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | cmd_ready high, waiting for a command
// S_BUS  | cyc/stb asserted, waiting for ack or terminal count
// S_RESP | response held on rsp_* until the consumer takes it
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        term;

    logic        cmd_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
    logic [31:0] rsp_dat_nxt;
    logic        cyc_nxt, stb_nxt, we_nxt;
    logic [31:0] adr_nxt, dat_nxt;
    logic [3:0]  sel_nxt;

    assign term = (cnt == CNT_LAST);

    // State and every output live in this one register bank.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_timeout <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_dat     <= rsp_dat_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            wbm_cyc_o   <= cyc_nxt;
            wbm_stb_o   <= stb_nxt;
            wbm_we_o    <= we_nxt;
            wbm_adr_o   <= adr_nxt;
            wbm_dat_o   <= dat_nxt;
            wbm_sel_o   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid)              state_nxt = S_BUS;
            S_BUS:   if (wbm_ack_i || term)      state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)              state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_nxt   = (state_nxt == S_IDLE);
        cnt_nxt         = cnt;
        rsp_valid_nxt   = rsp_valid;
        rsp_dat_nxt     = rsp_dat;
        rsp_timeout_nxt = rsp_timeout;
        cyc_nxt         = wbm_cyc_o;
        stb_nxt         = wbm_stb_o;
        we_nxt          = wbm_we_o;
        adr_nxt         = wbm_adr_o;
        dat_nxt         = wbm_dat_o;
        sel_nxt         = wbm_sel_o;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_nxt  = cmd_we;
                    adr_nxt = cmd_adr;
                    dat_nxt = cmd_dat;
                    sel_nxt = cmd_sel;
                    cyc_nxt = 1'b1;
                    stb_nxt = 1'b1;
                    cnt_nxt = '0;
                end
            end
            S_BUS: begin
                // Ack wins over a simultaneous terminal count.
                if (wbm_ack_i) begin
                    cyc_nxt         = 1'b0;
                    stb_nxt         = 1'b0;
                    rsp_dat_nxt     = wbm_we_o ? 32'd0 : wbm_dat_i;
                    rsp_timeout_nxt = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                end else if (term) begin
                    cyc_nxt         = 1'b0;
                    stb_nxt         = 1'b0;
                    rsp_dat_nxt     = 32'd0;
                    rsp_timeout_nxt = 1'b1;
                    rsp_valid_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule
